uart_loader: RTL and testbench

- Downstream consumer of the UART receive path; takes the byte stream and strobe produced by the UART receiver.
- Parses a framed load command and issues 32-bit word writes into MIPS instruction/data memory.
- Lets the host program the core over serial without resynthesis.
- Frame format:
  - sync byte;
  - 4-byte start address, big-endian;
  - 1-byte word count N;
  - N×4 data bytes, big-endian per word;
  - optional checksum byte.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_timeout_cnt.sv | 42 ++++
 rtl/uart_loader.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the serial program loader.
//   loader_state_t    : frame parser states
//   SYNC_BYTE_DEFAULT : default frame start marker
//   BIDX_W            : width of the byte-within-field index (0..3)
//   xor_byte()        : running-checksum update helper
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    CNT      = 3'd2,
    DATA     = 3'd3,
    WAIT_MEM = 3'd4,
    CSUM     = 3'd5
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Address and data fields are both 4 bytes long.
  localparam int unsigned BIDX_W = 2;

  // Fold one more byte into the running XOR checksum.
  function automatic logic [7:0] xor_byte(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// -----------------------------------------------------------------------------
// uart_timeout_cnt
// Inter-byte idle counter. Counts enabled cycles since the last clear and
// flags expiry when the count reaches TIMEOUT_CYCLES-1 while still enabled.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   clear_i  : restart the count (byte seen, or state that does not time out)
//   en_i     : count this cycle
//   expire_o : high for the cycle in which the limit is reached
// Parameters:
//   TIMEOUT_CYCLES : idle cycles tolerated between bytes (>= 2)
// -----------------------------------------------------------------------------
module uart_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Idle cycle counter; saturates at LAST so it never wraps back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Combinational so the parser can abort on the very edge the limit is hit;
  // a clear in the same cycle always wins.
  assign expire_o = en_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_loader.sv
// -----------------------------------------------------------------------------
// uart_loader
// Parses a serial load frame from the UART receiver and issues 32-bit word
// writes into instruction/data memory:
//   SYNC | ADDR[31:24] .. ADDR[7:0] | N | N x (D[31:24] .. D[7:0]) | [CSUM]
// Optional feature macro: UART_LOADER_CSUM_EN adds a trailing XOR checksum byte
// covering every byte after SYNC; when undefined err_csum is constant 0.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   rx_valid, rx_data   : one-cycle byte strobe and byte from the receiver
//   mem_ready           : memory accepts the pending write this cycle
//   mem_we              : write request, held until mem_ready
//   mem_addr, mem_wdata : word address (bits [1:0] = 0) and data of the write
//   busy                : frame in progress (any state but IDLE)
//   done                : pulse, frame completed
//   err_timeout         : pulse, inter-byte timeout abort
//   err_overrun         : pulse, byte arrived while a write was pending
//   err_csum            : pulse, checksum mismatch
// -----------------------------------------------------------------------------
module uart_loader
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_overrun,
  output logic              err_csum
);

  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(3);

  loader_state_t     state_q;
  logic [BIDX_W-1:0] bidx_q;
  logic [ADDR_W-1:0] addr_q;
  // Only the first three data bytes need storing; the fourth arrives with the write.
  logic [23:0]       word_q;
  logic [7:0]        cnt_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_timeout_q;
  logic              err_overrun_q;
`ifdef UART_LOADER_CSUM_EN
  logic [7:0]        csum_q;
  logic              err_csum_q;
`endif

  logic [ADDR_W-1:0] addr_shift_d;
  logic [ADDR_W-1:0] addr_inc_d;
  logic [31:0]       word_shift_d;
  logic              last_byte_d;
  logic              tmo_clear_d;
  logic              tmo_en_d;
  logic              tmo_expire;

  assign addr_shift_d = {addr_q[ADDR_W-9:0], rx_data};
  assign addr_inc_d   = addr_q + ADDR_W'(4);
  assign word_shift_d = {word_q, rx_data};
  assign last_byte_d  = (bidx_q == BIDX_LAST);

  // Timeout only runs while waiting on the host inside a frame.
  always_comb begin
    tmo_clear_d = 1'b0;
    tmo_en_d    = 1'b0;
    if (rx_valid || (state_q == IDLE) || (state_q == WAIT_MEM)) begin
      tmo_clear_d = 1'b1;
    end else begin
      tmo_en_d = 1'b1;
    end
  end

  uart_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmo_clear_d),
    .en_i     (tmo_en_d),
    .expire_o (tmo_expire)
  );

  // Frame parser with registered memory interface and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bidx_q        <= '0;
      addr_q        <= '0;
      word_q        <= '0;
      cnt_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
      csum_q        <= '0;
      err_csum_q    <= 1'b0;
`endif
    end else begin
      // Status pulses last a single cycle unless re-asserted below.
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
      err_csum_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_q <= ADDR;
            busy_q  <= 1'b1;
            bidx_q  <= '0;
            addr_q  <= '0;
`ifdef UART_LOADER_CSUM_EN
            csum_q  <= '0;
`endif
          end
        end

        ADDR: begin
          if (rx_valid) begin
`ifdef UART_LOADER_CSUM_EN
            csum_q <= xor_byte(csum_q, rx_data);
`endif
            bidx_q <= bidx_q + BIDX_W'(1);
            if (last_byte_d) begin
              // Word-align the completed address.
              addr_q  <= {addr_shift_d[ADDR_W-1:2], 2'b00};
              state_q <= CNT;
            end else begin
              addr_q <= addr_shift_d;
            end
          end else if (tmo_expire) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b1;
          end
        end

        CNT: begin
          if (rx_valid) begin
`ifdef UART_LOADER_CSUM_EN
            csum_q <= xor_byte(csum_q, rx_data);
`endif
            cnt_q  <= rx_data;
            bidx_q <= '0;
            if (rx_data == 8'd0) begin
`ifdef UART_LOADER_CSUM_EN
              state_q <= CSUM;
`else
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= DATA;
            end
          end else if (tmo_expire) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b1;
          end
        end

        DATA: begin
          if (rx_valid) begin
`ifdef UART_LOADER_CSUM_EN
            csum_q <= xor_byte(csum_q, rx_data);
`endif
            word_q <= word_shift_d[23:0];
            bidx_q <= bidx_q + BIDX_W'(1);
            if (last_byte_d) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_q;
              mem_wdata_q <= word_shift_d;
              state_q     <= WAIT_MEM;
            end
          end else if (tmo_expire) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b1;
          end
        end

        WAIT_MEM: begin
          if (mem_ready) begin
            mem_we_q <= 1'b0;
            addr_q   <= addr_inc_d;
            cnt_q    <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
`ifdef UART_LOADER_CSUM_EN
              // A byte arriving with the accept is the checksum itself.
              if (rx_valid) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                if (rx_data == csum_q) begin
                  done_q <= 1'b1;
                end else begin
                  err_csum_q <= 1'b1;
                end
              end else begin
                state_q <= CSUM;
              end
`else
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= DATA;
              // A byte arriving with the accept is byte 0 of the next word.
              if (rx_valid) begin
`ifdef UART_LOADER_CSUM_EN
                csum_q <= xor_byte(csum_q, rx_data);
`endif
                word_q <= word_shift_d[23:0];
                bidx_q <= BIDX_W'(1);
              end else begin
                bidx_q <= '0;
              end
            end
          end else if (rx_valid) begin
            // Host outran memory: abandon the pending write.
            mem_we_q      <= 1'b0;
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            err_overrun_q <= 1'b1;
          end
        end

`ifdef UART_LOADER_CSUM_EN
        CSUM: begin
          if (rx_valid) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (rx_data == csum_q) begin
              done_q <= 1'b1;
            end else begin
              err_csum_q <= 1'b1;
            end
          end else if (tmo_expire) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b1;
          end
        end
`endif

        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;
`ifdef UART_LOADER_CSUM_EN
  assign err_csum    = err_csum_q;
`else
  assign err_csum    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_loader
// Directed bench for uart_loader with TIMEOUT_CYCLES = 16. Inputs change 1 ns
// after the rising edge; a negedge monitor logs accepted writes and pulses.
// Checksum bytes are hand-computed XORs of every byte after SYNC and are only
// sent when UART_LOADER_CSUM_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic        err_overrun;
  logic        err_csum;

  always #5 clk = ~clk;

  uart_loader #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (16),
    .ADDR_W         (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .mem_ready   (mem_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .err_csum    (err_csum)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int tmo_cnt  = 0;
  int ovr_cnt  = 0;
  int csum_cnt = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write and pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we && mem_ready) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end
      if (done)        done_cnt++;
      if (err_timeout) tmo_cnt++;
      if (err_overrun) ovr_cnt++;
      if (err_csum)    csum_cnt++;
      if (done || err_timeout || err_overrun || err_csum) begin
        check_val("pulse_onehot", 32'(done) + 32'(err_timeout) + 32'(err_overrun) + 32'(err_csum), 32'd1);
        check_val("busy_at_pulse", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_hdr(input logic [31:0] a, input logic [7:0] n);
    send_byte(8'hA5);
    send_word(a);
    send_byte(n);
  endtask

  task automatic finish_frame(input logic [7:0] c);
`ifdef UART_LOADER_CSUM_EN
    send_byte(c);
`else
    rx_data = c;
`endif
  endtask

  task automatic wait_done(input int target, input string tag);
    int i;
    i = 0;
    while ((done_cnt < target) && (i < 40)) begin
      step();
      i++;
    end
    check_val(tag, done_cnt, target);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] ea, input logic [31:0] ed);
    logic [31:0] a;
    logic [31:0] d;
    if (wr_addr_q.size() == 0) begin
      check_val({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      a = wr_addr_q.pop_front();
      d = wr_data_q.pop_front();
      check_val({tag, "_addr"}, a, ea);
      check_val({tag, "_data"}, d, ed);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_flags"}, {26'd0, mem_we, busy, done, err_timeout, err_overrun, err_csum}, 32'd0);
    check_val({tag, "_addr"}, mem_addr, 32'd0);
    check_val({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int tmo_at;
    int done_snap;
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    mem_ready = 1'b0;
    repeat (3) step();
    check_idle_outputs("reset");
    rst = 1'b0;
    step();

    // Garbage before sync, then one word with memory always ready.
    mem_ready = 1'b1;
    send_byte(8'h5A);
    send_byte(8'hFF);
    check_val("garbage_idle", {31'd0, busy}, 32'd0);
    send_hdr(32'h0000_1000, 8'd1);
    check_val("t1_busy", {31'd0, busy}, 32'd1);
    send_word(32'hDEAD_BEEF);
    finish_frame(8'h33);
    wait_done(1, "t1_done");
    pop_check("t1_wr", 32'h0000_1000, 32'hDEAD_BEEF);

    // Two words, memory answers 3 cycles late; request must hold still.
    mem_ready = 1'b0;
    send_hdr(32'h0000_0006, 8'd2);
    send_word(32'h1122_3344);
    check_val("t2_we0", {31'd0, mem_we}, 32'd1);
    check_val("t2_addr0", mem_addr, 32'h0000_0004);
    check_val("t2_data0", mem_wdata, 32'h1122_3344);
    repeat (3) begin
      step();
      check_val("t2_hold_we", {31'd0, mem_we}, 32'd1);
      check_val("t2_hold_addr", mem_addr, 32'h0000_0004);
      check_val("t2_hold_data", mem_wdata, 32'h1122_3344);
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_val("t2_we_drop", {31'd0, mem_we}, 32'd0);
    check_val("t2_busy_mid", {31'd0, busy}, 32'd1);
    send_word(32'h5566_7788);
    check_val("t2_addr1", mem_addr, 32'h0000_0008);
    check_val("t2_data1", mem_wdata, 32'h5566_7788);
    repeat (3) begin
      step();
      check_val("t2_hold1_addr", mem_addr, 32'h0000_0008);
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    finish_frame(8'h8C);
    check_val("t2_done_pulse", {31'd0, done}, 32'd1);
    check_val("t2_busy_end", {31'd0, busy}, 32'd0);
    step();
    check_val("t2_done_once", {31'd0, done}, 32'd0);
    pop_check("t2_wr0", 32'h0000_0004, 32'h1122_3344);
    pop_check("t2_wr1", 32'h0000_0008, 32'h5566_7788);

    // Byte arrives while the write is still pending.
    done_snap = done_cnt;
    send_hdr(32'h0000_0020, 8'd1);
    send_word(32'hA1B2_C3D4);
    check_val("t3_we", {31'd0, mem_we}, 32'd1);
    step();
    send_byte(8'h99);
    check_val("t3_overrun", {31'd0, err_overrun}, 32'd1);
    check_val("t3_we_drop", {31'd0, mem_we}, 32'd0);
    check_val("t3_busy", {31'd0, busy}, 32'd0);
    check_val("t3_no_done", {31'd0, done}, 32'd0);
    step();
    check_val("t3_overrun_once", {31'd0, err_overrun}, 32'd0);
    check_val("t3_done_cnt", done_cnt, done_snap);
    check_val("t3_no_write", wr_addr_q.size(), 32'd0);

    // Host stalls mid-address.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    tmo_at = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (err_timeout) begin
        tmo_at = i;
        break;
      end
    end
    check_val("t4_tmo_cycles", tmo_at, 32'd16);
    check_val("t4_busy", {31'd0, busy}, 32'd0);
    mem_ready = 1'b1;
    send_hdr(32'h0000_2000, 8'd1);
    send_word(32'hCAFE_BABE);
    finish_frame(8'h11);
    wait_done(3, "t4_done_after");
    pop_check("t4_wr", 32'h0000_2000, 32'hCAFE_BABE);

    // Empty frame: no writes, completes straight away.
    send_hdr(32'h0000_0040, 8'd0);
    finish_frame(8'h40);
    check_val("t5_done", {31'd0, done}, 32'd1);
    step();
    check_val("t5_no_write", wr_addr_q.size(), 32'd0);

    // Address wrap; the accept of the first write coincides with the next byte.
    done_snap = done_cnt;
    send_hdr(32'hFFFF_FFFC, 8'd2);
    send_word(32'h0102_0304);
    send_byte(8'h05);
    send_byte(8'h06);
    send_byte(8'h07);
    mem_ready = 1'b0;
    send_byte(8'h08);
    check_val("t6_we", {31'd0, mem_we}, 32'd1);
    check_val("t6_wrap_addr", mem_addr, 32'h0000_0000);
    check_val("t6_data1", mem_wdata, 32'h0506_0708);
    pop_check("t6_wr0", 32'hFFFF_FFFC, 32'h0102_0304);
    rst = 1'b1;
    step();
    check_idle_outputs("t6_rst");
    rst = 1'b0;
    step();
    check_val("t6_no_done", done_cnt, done_snap);
    check_val("t6_no_write", wr_addr_q.size(), 32'd0);

`ifdef UART_LOADER_CSUM_EN
    // Wrong checksum byte.
    mem_ready = 1'b1;
    send_hdr(32'h0000_1000, 8'd1);
    send_word(32'hDEAD_BEEF);
    send_byte(8'h34);
    check_val("t7_err_csum", {31'd0, err_csum}, 32'd1);
    check_val("t7_no_done", {31'd0, done}, 32'd0);
    step();
    pop_check("t7_wr", 32'h0000_1000, 32'hDEAD_BEEF);
`endif

    step();
    check_val("total_done", done_cnt, 32'd4);
    check_val("total_tmo", tmo_cnt, 32'd1);
    check_val("total_ovr", ovr_cnt, 32'd1);
`ifdef UART_LOADER_CSUM_EN
    check_val("total_csum", csum_cnt, 32'd1);
`else
    check_val("total_csum", csum_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
